// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time configuration controller for the integer clock divider. Accepts
// divide-ratio change requests over a valid/ready handshake, waits for the
// divider's current output period to finish (tracked by a shadow phase
// counter), gates the divider clock enable low while the new ratio is loaded
// and settles, then restores the enable.
//
// Ports
//   i_ref_clk    in   reference clock, shared with the divider
//   i_rst_n      in   asynchronous active-low reset
//   i_req_valid  in   ratio change request
//   i_req_ratio  in   requested ratio [max_div_bits]
//   o_req_ready  out  request can be accepted (IDLE only)
//   i_enable     in   system-level divided-clock enable
//   o_div_ratio  out  ratio to divider, registered [max_div_bits]
//   o_clk_en     out  clock enable to divider, registered
//   o_busy       out  reconfiguration in progress
//   o_done       out  one-cycle pulse when a reconfiguration completes
//
// States
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | enable follows i_enable, waiting for a request
//   DRAIN  | request accepted, waiting for the current period to end
//   LOAD   | enable low, new ratio written to the divider
//   SETTLE | enable held low for settle_cycles while the divider settles
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int unsigned max_div_bits  = 4,
  parameter int unsigned rst_ratio     = 1,
  parameter int unsigned settle_cycles = 2
) (
  input  logic                    i_ref_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  input  logic [max_div_bits-1:0] i_req_ratio,
  output logic                    o_req_ready,
  input  logic                    i_enable,
  output logic [max_div_bits-1:0] o_div_ratio,
  output logic                    o_clk_en,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [max_div_bits-1:0] rst_ratio_v = max_div_bits'(rst_ratio);
  localparam logic [max_div_bits-1:0] ratio_one   = max_div_bits'(1);
  localparam logic [max_div_bits-1:0] ratio_two   = max_div_bits'(2);
  localparam logic [3:0]              settle_last = 4'(settle_cycles - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [max_div_bits-1:0] pending;
  logic [max_div_bits-1:0] phase;
  logic [3:0]              settle_cnt;

  logic [max_div_bits-1:0] div_ratio_nxt;
  logic                    clk_en_nxt;
  logic                    done_nxt;
  logic [3:0]              settle_cnt_nxt;

  logic                    accept;
  logic                    bypass;
  logic                    at_boundary;
  logic                    drain_exit;
  logic                    settle_end;

  // Ratios 0 and 1 pass the reference clock straight through, so there is
  // no period to wait for and the phase counter stays parked at 0.
  assign bypass      = (o_div_ratio < ratio_two);
  assign at_boundary = (phase == (o_div_ratio - ratio_one));
  assign drain_exit  = !o_clk_en || bypass || at_boundary;
  assign settle_end  = (settle_cnt == settle_last);

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign accept      = i_req_valid && o_req_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_exit) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered divider controls
  // ---------------------------------------------------------------------------
  always_comb begin
    div_ratio_nxt  = o_div_ratio;
    clk_en_nxt     = o_clk_en;
    done_nxt       = 1'b0;
    settle_cnt_nxt = settle_cnt;
    case (state)
      IDLE: begin
        clk_en_nxt = i_enable;
      end
      DRAIN: begin
        // The enable drops on the same edge that enters LOAD, so the ratio
        // written in LOAD is never seen by a running divider.
        if (drain_exit) begin
          clk_en_nxt = 1'b0;
        end
      end
      LOAD: begin
        div_ratio_nxt  = pending;
        clk_en_nxt     = 1'b0;
        settle_cnt_nxt = 4'd0;
      end
      SETTLE: begin
        clk_en_nxt = 1'b0;
        if (settle_end) begin
          clk_en_nxt = i_enable;
          done_nxt   = 1'b1;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      default: begin
        clk_en_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_div_ratio <= rst_ratio_v;
      o_clk_en    <= 1'b0;
      o_done      <= 1'b0;
      settle_cnt  <= 4'd0;
    end else begin
      o_div_ratio <= div_ratio_nxt;
      o_clk_en    <= clk_en_nxt;
      o_done      <= done_nxt;
      settle_cnt  <= settle_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending ratio, captured at the handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= rst_ratio_v;
    end else if (accept) begin
      pending <= i_req_ratio;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow phase counter: mirrors the divider's position within its period
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase <= '0;
    end else if (o_clk_en && !bypass) begin
      if (at_boundary) begin
        phase <= '0;
      end else begin
        phase <= phase + ratio_one;
      end
    end else begin
      phase <= '0;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Self-checking bench for clk_div_ctrl. Each request pushes its expected
// outcome (final ratio, enable at completion, accept-to-done latency and the
// number of busy cycles with the enable gated) into a scoreboard queue; a
// monitor pops and compares when o_done pulses. Expected latencies are
// derived from the known divider phase at the accept cycle.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int W      = 4;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_ratio = '0;
  logic         enable = 1'b0;
  logic         req_ready;
  logic [W-1:0] div_ratio;
  logic         clk_en;
  logic         busy;
  logic         done;

  clk_div_ctrl #(
    .max_div_bits (W),
    .rst_ratio    (1),
    .settle_cycles(SETTLE)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .i_req_ratio(req_ratio),
    .o_req_ready(req_ready),
    .i_enable   (enable),
    .o_div_ratio(div_ratio),
    .o_clk_en   (clk_en),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] ratio;
    logic         en;
    int           lat;
    int           gated;
  } exp_t;

  exp_t sb_q[$];

  // Drive a request at the current negedge, hold it until accepted, then drop.
  task automatic request(input logic [W-1:0] r, input int drain, input logic exp_en,
                         input int gated);
    exp_t e;
    int   waited;
    req_valid = 1'b1;
    req_ratio = r;
    waited    = 0;
    while (!req_ready && waited < 40) begin
      check_val("bp_busy", 32'(busy), 1);
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_val("accept_timeout", 32'(req_ready), 1);
    end else begin
      e = '{r, exp_en, drain + 2 + SETTLE, gated};
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_val("done_timeout", 32'(done), 1);
  endtask

  // Monitor: samples just after each negedge, once the bench has driven inputs.
  bit           m_tracking = 1'b0;
  int           m_lat = 0;
  int           m_gated = 0;
  logic [W-1:0] m_prev_ratio = 4'd1;
  logic         m_prev_en = 1'b0;
  exp_t         m_e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_tracking = 1'b0;
      end else begin
        if (m_tracking) begin
          m_lat++;
          if (busy && !clk_en) m_gated++;
        end
        if (div_ratio != m_prev_ratio)
          check_val("ratio_chg_while_en", 32'({m_prev_en, clk_en}), 0);
        if (done) begin
          if (sb_q.size() == 0) begin
            check_val("spurious_done", 32'(done), 0);
          end else begin
            m_e = sb_q.pop_front();
            check_val("done_ratio", 32'(div_ratio), 32'(m_e.ratio));
            check_val("done_clk_en", 32'(clk_en), 32'(m_e.en));
            check_val("done_latency", m_lat, m_e.lat);
            check_val("gated_cycles", m_gated, m_e.gated);
          end
          m_tracking = 1'b0;
        end
        if (req_valid && req_ready) begin
          m_tracking = 1'b1;
          m_lat      = 0;
          m_gated    = 0;
        end
      end
      m_prev_ratio = div_ratio;
      m_prev_en    = clk_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    #1 rst_n = 1'b0;
    #11;
    check_val("rst_ratio", 32'(div_ratio), 1);
    check_val("rst_clk_en", 32'(clk_en), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_ready", 32'(req_ready), 1);
    check_val("rst_done", 32'(done), 0);

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check_val("en_follow", 32'(clk_en), 1);

    // Bypass start: ratio 1 -> 4, DRAIN lasts one cycle.
    request(4'd4, 1, 1'b1, 3);
    wait_done();

    // Ratio 4 at phase 0 -> 6: drain until phase 3 (3 cycles).
    request(4'd6, 3, 1'b1, 3);
    wait_done();
    // Ratio 6, accept at phase 1 -> 3: drain phases 2..5 (4 cycles).
    @(negedge clk);
    request(4'd3, 4, 1'b1, 3);
    wait_done();

    // Back-pressure: second request held valid while the first is busy.
    request(4'd2, 2, 1'b1, 3);
    request(4'd8, 1, 1'b1, 3);
    wait_done();

    // Enable gating in IDLE.
    enable = 1'b0;
    @(negedge clk);
    check_val("en_off", 32'(clk_en), 0);
    request(4'd5, 1, 1'b0, 4);
    wait_done();
    request(4'd1, 1, 1'b0, 4);
    wait_done();
    enable = 1'b1;
    @(negedge clk);
    check_val("en_on", 32'(clk_en), 1);

    // Enable toggled 1 -> 0 -> 1 during SETTLE; completion samples 1.
    request(4'd7, 1, 1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_done();

    // Ratio 7 at phase 0 -> 2: drain 6 cycles; enable drops on the last SETTLE cycle.
    request(4'd2, 6, 1'b0, 3);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    wait_done();

    // Reset in the middle of SETTLE.
    enable = 1'b1;
    @(negedge clk);
    request(4'd5, 1, 1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    check_val("settle_ratio", 32'(div_ratio), 5);
    check_val("settle_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_ratio", 32'(div_ratio), 1);
    check_val("midrst_clk_en", 32'(clk_en), 0);
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_ready", 32'(req_ready), 1);
    check_val("midrst_done", 32'(done), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("no_done_after_rst", n_done, 0);
    check_val("post_rst_ratio", 32'(div_ratio), 1);
    check_val("post_rst_clk_en", 32'(clk_en), 1);
    check_val("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
